// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the datapath.
// Fetch T0..T2 with stretchable T1, opcode-driven execute T3..T6.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic [4:0]  alu_op,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait;
  logic        r_illegal;

  logic [4:0]  w_op;
  logic [15:0] w_ra;
  logic [15:0] w_rb;
  logic [15:0] w_rc;
  logic        w_alu3;
  logic        w_muldiv;
  logic        w_negnot;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_nop;
  logic        w_halt;
  logic        w_unused_ir;

  assign w_op     = ir[31:27];
  assign w_ra     = 16'd1 << ir[26:23];
  assign w_rb     = 16'd1 << ir[22:19];
  assign w_rc     = 16'd1 << ir[18:15];
  assign w_alu3   = (w_op >= 5'd3) && (w_op <= 5'd14);
  assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_negnot = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_mfhi   = (w_op == 5'd23);
  assign w_mflo   = (w_op == 5'd24);
  assign w_nop    = (w_op == 5'd25);
  assign w_halt   = (w_op == 5'd26);
  assign w_unused_ir = ^ir[14:0];

  // State register, T1 wait counter and sticky illegal flag
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_state   <= S_RESET;
      r_wait    <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_T0;
        S_T0:    r_state <= S_T1;
        S_T1: begin
          if (r_wait == 4'(MEM_WAIT)) begin
            r_state <= S_T2;
            r_wait  <= 4'd0;
          end else begin
            r_wait  <= r_wait + 4'd1;
          end
        end
        S_T2:    r_state <= S_T3;
        S_T3: begin
          if (w_alu3 || w_muldiv || w_negnot) begin
            r_state <= S_T4;
          end else if (w_mfhi || w_mflo || w_nop) begin
            r_state <= S_T0;
          end else if (w_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end
        end
        S_T4:    r_state <= (w_alu3 || w_muldiv) ? S_T5 : S_T0;
        S_T5:    r_state <= w_muldiv ? S_T6 : S_T0;
        S_T6:    r_state <= S_T0;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RESET;
      endcase
    end
  end

  // Moore strobe decode from state, ir and wait counter
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    Read = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0;
    LOout = 1'b0;
    alu_op  = 5'd0;
    reg_in  = 16'd0;
    reg_out = 16'd0;
    run     = (r_state != S_RESET) && (r_state != S_HALT);
    illegal = r_illegal;
    case (r_state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        if (r_wait == 4'd0) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          w_alu3: begin
            reg_out = w_rb; Yin = 1'b1;
          end
          w_muldiv: begin
            reg_out = w_ra; Yin = 1'b1;
          end
          w_negnot: begin
            reg_out = w_rb; Zin = 1'b1;
            alu_op = w_op;
          end
          w_mfhi: begin
            HIout = 1'b1; reg_in = w_ra;
          end
          w_mflo: begin
            LOout = 1'b1; reg_in = w_ra;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_alu3: begin
            reg_out = w_rc; Zin = 1'b1;
            alu_op = w_op;
          end
          w_muldiv: begin
            reg_out = w_rb; Zin = 1'b1;
            alu_op = w_op;
          end
          w_negnot: begin
            Zlowout = 1'b1; reg_in = w_ra;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_alu3: begin
            Zlowout = 1'b1; reg_in = w_ra;
          end
          w_muldiv: begin
            Zlowout = 1'b1; LOin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Two instances: MEM_WAIT=0 and MEM_WAIT=2.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = 32'hFFFF_FFFF;

  always #5 Clock = ~Clock;

  localparam logic [15:0] PCO = 16'h8000;
  localparam logic [15:0] PCI = 16'h4000;
  localparam logic [15:0] INC = 16'h2000;
  localparam logic [15:0] MAR = 16'h1000;
  localparam logic [15:0] MDI = 16'h0800;
  localparam logic [15:0] MDO = 16'h0400;
  localparam logic [15:0] RD  = 16'h0200;
  localparam logic [15:0] IRI = 16'h0100;
  localparam logic [15:0] YI  = 16'h0080;
  localparam logic [15:0] ZI  = 16'h0040;
  localparam logic [15:0] ZHO = 16'h0020;
  localparam logic [15:0] ZLO = 16'h0010;
  localparam logic [15:0] HII = 16'h0008;
  localparam logic [15:0] LOI = 16'h0004;
  localparam logic [15:0] HIO = 16'h0002;
  localparam logic [15:0] LOO = 16'h0001;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic a_PCout, a_PCin, a_IncPC, a_MARin, a_MDRin, a_MDRout;
  logic a_Read, a_IRin, a_Yin, a_Zin, a_Zhighout, a_Zlowout;
  logic a_HIin, a_LOin, a_HIout, a_LOout, a_run, a_illegal;
  logic [4:0]  a_alu_op;
  logic [15:0] a_reg_in, a_reg_out;

  logic b_PCout, b_PCin, b_IncPC, b_MARin, b_MDRin, b_MDRout;
  logic b_Read, b_IRin, b_Yin, b_Zin, b_Zhighout, b_Zlowout;
  logic b_HIin, b_LOin, b_HIout, b_LOout, b_run, b_illegal;
  logic [4:0]  b_alu_op;
  logic [15:0] b_reg_in, b_reg_out;

  control_sequencer #(.MEM_WAIT(0)) u0 (
    .Clock(Clock), .clear(clear), .ir(ir),
    .PCout(a_PCout), .PCin(a_PCin), .IncPC(a_IncPC),
    .MARin(a_MARin), .MDRin(a_MDRin), .MDRout(a_MDRout),
    .Read(a_Read), .IRin(a_IRin), .Yin(a_Yin), .Zin(a_Zin),
    .Zhighout(a_Zhighout), .Zlowout(a_Zlowout),
    .HIin(a_HIin), .LOin(a_LOin), .HIout(a_HIout), .LOout(a_LOout),
    .alu_op(a_alu_op), .reg_in(a_reg_in), .reg_out(a_reg_out),
    .run(a_run), .illegal(a_illegal)
  );

  control_sequencer #(.MEM_WAIT(2)) u2 (
    .Clock(Clock), .clear(clear), .ir(ir),
    .PCout(b_PCout), .PCin(b_PCin), .IncPC(b_IncPC),
    .MARin(b_MARin), .MDRin(b_MDRin), .MDRout(b_MDRout),
    .Read(b_Read), .IRin(b_IRin), .Yin(b_Yin), .Zin(b_Zin),
    .Zhighout(b_Zhighout), .Zlowout(b_Zlowout),
    .HIin(b_HIin), .LOin(b_LOin), .HIout(b_HIout), .LOout(b_LOout),
    .alu_op(b_alu_op), .reg_in(b_reg_in), .reg_out(b_reg_out),
    .run(b_run), .illegal(b_illegal)
  );

  logic [54:0] v0, v2;
  assign v0 = {a_PCout, a_PCin, a_IncPC, a_MARin, a_MDRin, a_MDRout,
               a_Read, a_IRin, a_Yin, a_Zin, a_Zhighout, a_Zlowout,
               a_HIin, a_LOin, a_HIout, a_LOout,
               a_alu_op, a_reg_in, a_reg_out, a_run, a_illegal};
  assign v2 = {b_PCout, b_PCin, b_IncPC, b_MARin, b_MDRin, b_MDRout,
               b_Read, b_IRin, b_Yin, b_Zin, b_Zhighout, b_Zlowout,
               b_HIin, b_LOin, b_HIout, b_LOout,
               b_alu_op, b_reg_in, b_reg_out, b_run, b_illegal};

  logic [54:0] q0[$];
  logic [54:0] q2[$];
  string       n0[$];
  string       n2[$];
  int total = 0;
  int bad = 0;

  function automatic logic [54:0] ex(
    input logic [15:0] s, input logic [4:0] a,
    input logic [15:0] ri, input logic [15:0] ro,
    input logic rn, input logic il);
    return {s, a, ri, ro, rn, il};
  endfunction

  // Monitor: pop expected vectors and compare mid-cycle
  always @(negedge Clock) begin
    logic [54:0] e;
    string nm;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      nm = n0.pop_front();
      total++;
      if (v0 !== e) begin
        bad++;
        $display("FAIL %s mw0 got %h want %h", nm, v0, e);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      nm = n2.pop_front();
      total++;
      if (v2 !== e) begin
        bad++;
        $display("FAIL %s mw2 got %h want %h", nm, v2, e);
      end
    end
  end

  task automatic step(input logic clr, input logic [54:0] e,
                      input string nm);
    clear = clr;
    @(posedge Clock);
    #1;
    q0.push_back(e);
    n0.push_back(nm);
  endtask

  task automatic step2(input logic clr, input logic [54:0] e,
                       input string nm);
    clear = clr;
    @(posedge Clock);
    #1;
    q2.push_back(e);
    n2.push_back(nm);
  endtask

  logic [54:0] Z, T0E, T1E, T2E, RUN;

  // Fetch with junk in ir until IR would be loaded
  task automatic fetch(input logic [31:0] instr);
    step(1'b0, T0E, "T0");
    ir = JUNK;
    step(1'b0, T1E, "T1");
    step(1'b0, T2E, "T2");
    ir = instr;
  endtask

  initial begin
    Z   = ex(16'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    RUN = ex(16'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    T0E = ex(PCO | MAR | INC | ZI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    T1E = ex(RD | MDI | ZLO | PCI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    T2E = ex(MDO | IRI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);

    step(1'b1, Z, "reset");
    step(1'b1, Z, "reset2");

    fetch(32'h2891_8000);
    step(1'b0, ex(YI, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0), "and_T3");
    step(1'b0, ex(ZI, 5'd5, 16'h0, 16'h0008, 1'b1, 1'b0), "and_T4");
    step(1'b0, ex(ZLO, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0), "and_T5");

    fetch(32'h1822_8000);
    step(1'b0, ex(YI, 5'd0, 16'h0, 16'h0010, 1'b1, 1'b0), "add_T3");
    step(1'b0, ex(ZI, 5'd3, 16'h0, 16'h0020, 1'b1, 1'b0), "add_T4");
    step(1'b0, ex(ZLO, 5'd0, 16'h0001, 16'h0, 1'b1, 1'b0), "add_T5");

    fetch(32'h7B38_0000);
    step(1'b0, ex(YI, 5'd0, 16'h0, 16'h0040, 1'b1, 1'b0), "mul_T3");
    step(1'b0, ex(ZI, 5'd15, 16'h0, 16'h0080, 1'b1, 1'b0), "mul_T4");
    step(1'b0, ex(ZLO | LOI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "mul_T5");
    step(1'b0, ex(ZHO | HII, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "mul_T6");

    fetch(32'h8918_0000);
    step(1'b0, ex(ZI, 5'd17, 16'h0, 16'h0008, 1'b1, 1'b0), "neg_T3");
    step(1'b0, ex(ZLO, 5'd0, 16'h0004, 16'h0, 1'b1, 1'b0), "neg_T4");

    fetch(32'hBA80_0000);
    step(1'b0, ex(HIO, 5'd0, 16'h0020, 16'h0, 1'b1, 1'b0), "mfhi_T3");

    fetch(32'hC280_0000);
    step(1'b0, ex(LOO, 5'd0, 16'h0020, 16'h0, 1'b1, 1'b0), "mflo_T3");

    fetch(32'hC800_0000);
    step(1'b0, RUN, "nop_T3");

    fetch(32'hD000_0000);
    step(1'b0, RUN, "halt_T3");
    for (int i = 0; i < 20; i++) step(1'b0, Z, "halted");
    step(1'b1, Z, "clr_halt");

    fetch(32'hF800_0000);
    step(1'b0, RUN, "ill_T3");
    for (int i = 0; i < 4; i++)
      step(1'b0, ex(16'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1), "ill_halt");
    step(1'b1, Z, "ill_clr");
    ir = JUNK;
    step(1'b0, T0E, "after_clr_T0");
    step(1'b0, T1E, "after_clr_T1");
    step(1'b1, Z, "clr_T1");

    fetch(32'h1822_8000);
    step(1'b0, ex(YI, 5'd0, 16'h0, 16'h0010, 1'b1, 1'b0), "abort_T3");
    step(1'b0, ex(ZI, 5'd3, 16'h0, 16'h0020, 1'b1, 1'b0), "abort_T4");
    step(1'b1, Z, "abort_clr");
    step(1'b0, T0E, "abort_T0");

    step2(1'b1, Z, "w_reset");
    ir = JUNK;
    step2(1'b0, T0E, "w_T0");
    step2(1'b0, T1E, "w_T1a");
    step2(1'b0, ex(RD | MDI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "w_T1b");
    step2(1'b0, ex(RD | MDI, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), "w_T1c");
    step2(1'b0, T2E, "w_T2");
    ir = 32'hC800_0000;
    step2(1'b0, RUN, "w_T3");
    step2(1'b0, T0E, "w_T0b");

    @(posedge Clock);
    @(posedge Clock);
    total++;
    if (q0.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL drain left %0d want 0", q0.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
